// File: rtl/usb_log_capture.sv
// USB receive logger: stores each received packet as bytes in a data FIFO and a
// 64-bit descriptor in a meta FIFO, both drained by a host-side consumer.
module usb_log_capture #(
    parameter int unsigned DATA_DEPTH = 2048,
    parameter int unsigned META_DEPTH = 16,
    parameter int unsigned MAX_LEN    = 504
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        rx_active,
    input  logic        rx_error,
    output logic        available,
    output logic [63:0] meta,
    input  logic        meta_en,
    output logic [7:0]  data,
    output logic        data_stop,
    input  logic        data_en
);
    localparam int unsigned DAW       = $clog2(DATA_DEPTH);
    localparam int unsigned MAW       = $clog2(META_DEPTH);
    localparam logic [8:0]  MAX_CNT   = 9'(MAX_LEN);
    localparam logic [DAW:0] DATA_FULL = (DAW+1)'(DATA_DEPTH);
    localparam logic [MAW:0] META_FULL = (MAW+1)'(META_DEPTH);

    typedef enum logic [1:0] {IDLE, RECV, DROP, FINISH} state_t;
    state_t state, state_n;

    logic [31:0] ts, ts_start;
    logic        act_q;
    logic [7:0]  pend;
    logic [8:0]  cnt;
    logic        err_f, trunc_f, drop_pend;

    logic        rise_c;
    logic        data_wr_c, meta_wr_c;
    logic [8:0]  data_wdata_c;
    logic [63:0] meta_wdata_c;

    assign rise_c       = rx_active & ~act_q;
    assign meta_wdata_c = {ts_start, err_f, trunc_f, drop_pend, 20'd0, cnt};

    // Data FIFO
    logic [8:0]     dmem [DATA_DEPTH];
    logic [DAW-1:0] d_wp, d_rp;
    logic [DAW:0]   d_cnt;
    logic           d_wr_c, d_rd_c, hold;
    logic [8:0]     d_word_c;

    // Meta FIFO
    logic [63:0]    mmem [META_DEPTH];
    logic [MAW-1:0] m_wp, m_rp;
    logic [MAW:0]   m_cnt, m_cnt_n_c;
    logic           m_wr_c, m_rd_c;
    logic [63:0]    m_word_c;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_n;
    end

    // Next state and FIFO write strobes
    always_comb begin
        state_n      = state;
        data_wr_c    = 1'b0;
        data_wdata_c = 9'd0;
        meta_wr_c    = 1'b0;
        unique case (state)
            IDLE: begin
                if (rise_c) begin
                    if ((DATA_DEPTH - 32'(d_cnt)) >= (MAX_LEN + 32'd1) && (m_cnt != META_FULL))
                        state_n = RECV;
                    else
                        state_n = DROP;
                end
            end
            RECV: begin
                if (!rx_active) begin
                    state_n = (cnt != 9'd0) ? FINISH : IDLE;
                end else if (rx_valid && cnt != 9'd0 && cnt < MAX_CNT) begin
                    data_wr_c    = 1'b1;
                    data_wdata_c = {1'b0, pend};
                end
            end
            FINISH: begin
                data_wr_c    = 1'b1;
                data_wdata_c = {1'b1, pend};
                meta_wr_c    = 1'b1;
                state_n      = IDLE;
            end
            DROP: begin
                if (!rx_active) state_n = IDLE;
            end
        endcase
    end

    // Timestamp and per-packet capture registers; act_q resets high so a packet
    // already in flight at reset release is not mistaken for a new one.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ts        <= 32'd0;
            ts_start  <= 32'd0;
            act_q     <= 1'b1;
            pend      <= 8'd0;
            cnt       <= 9'd0;
            err_f     <= 1'b0;
            trunc_f   <= 1'b0;
            drop_pend <= 1'b0;
        end else begin
            ts    <= ts + 32'd1;
            act_q <= rx_active;
            if (state == IDLE && rise_c) begin
                ts_start <= ts;
                cnt      <= 9'd0;
                err_f    <= 1'b0;
                trunc_f  <= 1'b0;
            end
            if (state == RECV && rx_active) begin
                if (rx_error) err_f <= 1'b1;
                if (rx_valid) begin
                    if (cnt < MAX_CNT) begin
                        pend <= rx_data;
                        cnt  <= cnt + 9'd1;
                    end else begin
                        trunc_f <= 1'b1;
                    end
                end
            end
            if (state == DROP)        drop_pend <= 1'b1;
            else if (state == FINISH) drop_pend <= 1'b0;
        end
    end

    // A read of an empty FIFO is honoured only when a write lands in the same cycle
    assign d_rd_c   = data_en & ~hold & ((d_cnt != '0) | data_wr_c);
    assign d_wr_c   = data_wr_c & ((d_cnt != DATA_FULL) | d_rd_c);
    assign d_word_c = (d_cnt == '0) ? data_wdata_c : dmem[d_rp];

    always_ff @(posedge clock) begin
        if (d_wr_c) dmem[d_wp] <= data_wdata_c;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            d_wp      <= '0;
            d_rp      <= '0;
            d_cnt     <= '0;
            data      <= 8'd0;
            data_stop <= 1'b0;
            hold      <= 1'b0;
        end else begin
            if (d_wr_c) d_wp <= d_wp + DAW'(1);
            if (d_rd_c) begin
                d_rp      <= d_rp + DAW'(1);
                data      <= d_word_c[7:0];
                data_stop <= d_word_c[8];
                hold      <= d_word_c[8];
            end else if (meta_en) begin
                hold <= 1'b0;
            end
            if (d_wr_c && !d_rd_c)      d_cnt <= d_cnt + (DAW+1)'(1);
            else if (!d_wr_c && d_rd_c) d_cnt <= d_cnt - (DAW+1)'(1);
        end
    end

    assign m_rd_c   = meta_en & ((m_cnt != '0) | meta_wr_c);
    assign m_wr_c   = meta_wr_c & ((m_cnt != META_FULL) | m_rd_c);
    assign m_word_c = (m_cnt == '0) ? meta_wdata_c : mmem[m_rp];

    always_comb begin
        m_cnt_n_c = m_cnt;
        if (m_wr_c && !m_rd_c)      m_cnt_n_c = m_cnt + (MAW+1)'(1);
        else if (!m_wr_c && m_rd_c) m_cnt_n_c = m_cnt - (MAW+1)'(1);
    end

    always_ff @(posedge clock) begin
        if (m_wr_c) mmem[m_wp] <= meta_wdata_c;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_wp      <= '0;
            m_rp      <= '0;
            m_cnt     <= '0;
            meta      <= 64'd0;
            available <= 1'b0;
        end else begin
            if (m_wr_c) m_wp <= m_wp + MAW'(1);
            if (m_rd_c) begin
                m_rp <= m_rp + MAW'(1);
                meta <= m_word_c;
            end
            m_cnt     <= m_cnt_n_c;
            available <= (m_cnt_n_c != '0);
        end
    end

endmodule

// File: doc/usb_log_capture.md
USB_LOG_CAPTURE -- requirements
Module: usb_log_capture

Interface
REQ-001 SHALL have parameter DATA_DEPTH, default 2048, data FIFO entries (power of 2, 9 bits each: byte plus stop flag).
REQ-002 SHALL have parameter META_DEPTH, default 16, meta FIFO entries (power of 2, 64 bits each).
REQ-003 SHALL have parameter MAX_LEN, default 504, max stored bytes per packet (512-byte IN buffer minus 8 meta bytes).
REQ-004 clock  in  1  single clock; all logic on rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 rx_data  in  8  received packet byte.
REQ-007 rx_valid  in  1  rx_data valid this cycle; qualified by rx_active.
REQ-008 rx_active  in  1  high for the duration of one received packet.
REQ-009 rx_error  in  1  PHY error strobe, sampled while rx_active.
REQ-010 available  out  1  at least one complete packet is queued.
REQ-011 meta  out  64  packet descriptor; registered FIFO output.
REQ-012 meta_en  in  1  meta FIFO pop request.
REQ-013 data  out  8  packet byte; registered FIFO output.
REQ-014 data_stop  out  1  the byte on data is the last of its packet.
REQ-015 data_en  in  1  data FIFO pop request.

Function
REQ-016 SHALL run a free-running 32-bit timestamp counter, incrementing every cycle and wrapping from FFFFFFFF to 0.
REQ-017 SHALL implement states IDLE, RECV, DROP, FINISH.
REQ-018 IDLE: on rx_active rising, latch timestamp; go to RECV if data FIFO free >= MAX_LEN+1 and meta FIFO not full, else go to DROP.
REQ-019 RECV: accept a byte only on rx_valid & rx_active; hold the newest byte in a one-byte pending register; on each new byte, write the previous pending byte to the data FIFO with stop=0.
REQ-020 RECV: bytes beyond MAX_LEN SHALL be discarded and the truncated flag set; the stored count saturates at MAX_LEN.
REQ-021 RECV: rx_error sampled high on any cycle with rx_active high SHALL set the error flag for the packet.
REQ-022 RECV: on rx_active falling, go to FINISH if the count >= 1; if the count = 0, go to IDLE with no FIFO writes.
REQ-023 FINISH (one cycle): write the pending byte with stop=1 and write the meta word in the same cycle, clear drop_pending, then go to IDLE.
REQ-024 DROP: write nothing, set drop_pending, and return to IDLE on rx_active falling.
REQ-025 Meta format SHALL be: [63:32] start timestamp, [31] error, [30] truncated, [29] drop_pending (packets dropped before this one), [28:9] zero, [8:0] stored byte count (1..MAX_LEN).
REQ-026 available SHALL equal meta FIFO not-empty, registered; meta is written only after the packet's last data byte, so available never precedes the data.
REQ-027 meta_en high SHALL pop one entry; meta updates on the next cycle and holds until the next pop; meta_en while empty SHALL be ignored.
REQ-028 data_en high SHALL pop one entry; data and data_stop update on the next cycle.
REQ-029 SHALL set a boundary-hold flag when the popped entry has stop=1; while the flag is set, data_en SHALL be ignored; meta_en SHALL clear the flag. This makes the consumer's one trailing data_en harmless.
REQ-030 data_en while the data FIFO is empty SHALL be ignored, with no pointer change.
REQ-031 Simultaneous FIFO read and write SHALL both take effect in the same cycle, including when a FIFO is full or empty.
REQ-032 Sources SHALL keep rx_active low for >= 2 cycles between packets; bytes arriving in FINISH are outside the contract.
REQ-033 Meta FIFO full implies the packet is dropped at start; data FIFO overflow mid-packet is impossible by the REQ-018 check.

Reset
REQ-034 On reset_n low, asynchronously: state=IDLE, FIFOs empty, timestamp=0, all flags clear, available=0, meta=0, data=0, data_stop=0.
REQ-035 Reset assertion mid-packet SHALL discard the partial packet; after release, capture resumes at the next rx_active rising edge.

Verification
REQ-036 3-byte packet A1 B2 C3 -> available=1; meta[8:0]=3 and flags 0; popped data A1,B2,C3 with data_stop only on C3; an extra data_en after C3 pops nothing.
REQ-037 600-byte packet -> meta[8:0]=504, meta[30]=1; 504 bytes stored with data_stop on byte 504.
REQ-038 Fill the meta FIFO with 16 packets, send a 17th, drain one, send an 18th -> the 17th is absent; the 18th meta has [29]=1.
REQ-039 rx_active pulse with no rx_valid -> no writes; available stays 0.
REQ-040 rx_error pulse mid-packet -> meta[31]=1; the packet is still stored intact.
REQ-041 reset_n low during byte 5 of a packet -> FIFOs empty, available=0; the next 2-byte packet is captured correctly with timestamp restarted from 0.
